// File: rtl/i2c_read_scheduler_pkg.sv
// i2c_sched_pkg: state encoding, default widths and timeout counter sizing for the I2C read scheduler
package i2c_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
   function automatic int cnt_w(input int timeout);
      return $clog2(timeout);
   endfunction

endpackage

// File: rtl/i2c_read_scheduler_if.sv
// i2c_read_scheduler_if: requester and master-side signals of the I2C read scheduler
// master modport: the scheduler (drives grants, responses and master commands)
// slave modport : the environment (drives requests and master completions)
interface i2c_read_scheduler_if
   import i2c_sched_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic [NREQ-1:0]        req;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        resp_valid;
   logic [DATA_W-1:0]      resp_data;
   logic                   resp_err;
   logic [ADDR_W-1:0]      m_addr;
   logic                   m_start;
   logic                   m_abort;
   logic                   m_done;
   logic [DATA_W-1:0]      m_data;
   logic                   m_nack;

   modport master (
      input  req, req_addr, m_done, m_data, m_nack,
      output gnt, resp_valid, resp_data, resp_err, m_addr, m_start, m_abort
   );

   modport slave (
      output req, req_addr, m_done, m_data, m_nack,
      input  gnt, resp_valid, resp_data, resp_err, m_addr, m_start, m_abort
   );

endinterface

// File: rtl/i2c_read_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
// req: request vector; ptr: highest-priority index
// gnt: one-hot winner; idx: winner index; any: at least one request present
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      idx = '0;
      any = |req;
      // Offsets are walked from farthest to nearest, so the requester closest to ptr is written last and wins.
      for (int k = NREQ - 1; k >= 0; k--)
         for (int j = 0; j < NREQ; j++)
            if (req[j] && IW'((int'(ptr) + k) % NREQ) == IW'(j)) idx = IW'(j);
      gnt = any ? NREQ'(1) << idx : '0;
   end

endmodule

// File: rtl/i2c_read_scheduler.sv
// i2c_read_scheduler: round-robin sharing of one I2C master among NREQ one-byte read requesters
// clk/rst: single clock, synchronous active-high reset
// bus    : requests/grants/responses toward requesters, address/start/abort/done toward the master
module i2c_read_scheduler
   import i2c_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 1024
) (
   input logic                  clk,
   input logic                  rst,
   i2c_read_scheduler_if.master bus
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = cnt_w(TIMEOUT);

   state_t            state, nxt;
   logic [IW-1:0]     idx, rr_ptr, arb_idx;
   logic [NREQ-1:0]   arb_gnt;
   logic              arb_any, expire;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] sel_addr;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req (bus.req),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_comb begin
      sel_addr = '0;
      for (int k = 0; k < NREQ; k++)
         if (arb_idx == IW'(k)) sel_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
   end

   // A completion arriving in the expiry cycle wins over the timeout.
   always_comb begin
      nxt    = state;
      expire = 1'b0;
      case (state)
         IDLE:  nxt = arb_any ? ISSUE : IDLE;
         ISSUE: nxt = WAIT;
         WAIT: begin
            expire = !bus.m_done && cnt == CW'(TIMEOUT - 1);
            nxt    = (bus.m_done || expire) ? RESP : WAIT;
         end
         default: nxt = IDLE;
      endcase
   end

   // Outputs are loaded on the edge entering the state that presents them, keeping them registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= '0;
         rr_ptr         <= '0;
         cnt            <= '0;
         bus.gnt        <= '0;
         bus.resp_valid <= '0;
         bus.resp_data  <= '0;
         bus.resp_err   <= 1'b0;
         bus.m_addr     <= '0;
         bus.m_start    <= 1'b0;
         bus.m_abort    <= 1'b0;
      end else begin
         state          <= nxt;
         cnt            <= (nxt == WAIT) ? cnt + 1'b1 : '0;
         bus.gnt        <= (nxt == ISSUE) ? arb_gnt : '0;
         bus.m_start    <= nxt == ISSUE;
         bus.m_abort    <= expire;
         bus.resp_valid <= (nxt == RESP) ? NREQ'(1) << idx : '0;
         if (nxt == ISSUE) begin
            idx        <= arb_idx;
            bus.m_addr <= sel_addr;
         end
         if (state == ISSUE) rr_ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
         if (state == WAIT && bus.m_done) begin
            bus.resp_data <= bus.m_data;
            bus.resp_err  <= bus.m_nack;
         end else if (expire) begin
            bus.resp_data <= '0;
            bus.resp_err  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2c_read_scheduler.sv
// tb_i2c_read_scheduler: table, hand-written and randomized checks of the I2C read scheduler
module tb_i2c_read_scheduler;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;

   typedef struct {
      logic [3:0] req;
      logic [7:0] addr;
      int         lat;
      logic [7:0] d;
      logic       nk;
      int         w;
      logic [7:0] ed;
      logic       ee;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         tests = 0;
   int         fails = 0;
   int         ptr = 0;
   logic [7:0] addr [NREQ];
   vec_t       vt [10];

   i2c_read_scheduler_if #(.NREQ(NREQ), .ADDR_W(8), .DATA_W(8)) bus ();

   i2c_read_scheduler #(.NREQ(NREQ), .ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference arbitration: nearest requester at or above ptr, wrapping.
   function automatic int winner(input logic [3:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return 0;
   endfunction

   function automatic logic [31:0] all_outs();
      return {5'd0, bus.gnt, bus.resp_valid, bus.m_start, bus.m_abort, bus.resp_data, bus.resp_err, bus.m_addr};
   endfunction

   // One full transaction starting from IDLE: grant, master latency (or timeout), response.
   task automatic run_txn(input string nm, input logic [3:0] r, input logic [7:0] a, input int lat,
                          input logic [7:0] d, input logic nk, input int w, input logic [7:0] ed, input logic ee);
      int   n   = 0;
      logic bad = 1'b0;
      logic to  = lat >= TIMEOUT;
      addr[w] = a;
      bus.req_addr = {addr[3], addr[2], addr[1], addr[0]};
      bus.req = r;
      do begin
         tick();
         n++;
      end while (bus.gnt == '0 && n < 8);
      chk({nm, " gnt latency"}, n, 1);
      chk({nm, " gnt"}, bus.gnt, 1 << w);
      chk({nm, " m_start"}, bus.m_start, 1);
      chk({nm, " m_addr"}, bus.m_addr, a);
      ptr = (w + 1) % NREQ;
      for (int k = 0; k < (to ? TIMEOUT - 1 : lat); k++) begin
         tick();
         if (bus.gnt != '0 || bus.m_start || bus.m_abort || bus.resp_valid != '0 || bus.m_addr != a) bad = 1'b1;
      end
      chk({nm, " quiet wait"}, bad, 0);
      if (!to) begin
         bus.m_done = 1'b1;
         bus.m_data = d;
         bus.m_nack = nk;
      end
      tick();
      bus.m_done = 1'b0;
      bus.m_nack = 1'b0;
      chk({nm, " resp_valid"}, bus.resp_valid, 1 << w);
      chk({nm, " resp_data"}, bus.resp_data, ed);
      chk({nm, " resp_err"}, bus.resp_err, ee);
      chk({nm, " m_abort"}, bus.m_abort, to);
      tick();
      chk({nm, " pulses end"}, {bus.gnt, bus.resp_valid, bus.m_start, bus.m_abort}, 0);
      chk({nm, " m_addr held"}, bus.m_addr, a);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] r;
      logic [7:0] a, d;
      logic       nk, bad;
      int         w, lat, n;
      addr = '{8'h1A, 8'h1B, 8'h2A, 8'h2B};
      bus.req      = '0;
      bus.req_addr = {addr[3], addr[2], addr[1], addr[0]};
      bus.m_done   = 1'b0;
      bus.m_data   = '0;
      bus.m_nack   = 1'b0;
      vt[0] = '{4'b1111, 8'h1A, 6,  8'h5D, 1'b0, 0, 8'h5D, 1'b0};
      vt[1] = '{4'b1111, 8'h1B, 7,  8'h3F, 1'b0, 1, 8'h3F, 1'b0};
      vt[2] = '{4'b1111, 8'h2A, 8,  8'h41, 1'b0, 2, 8'h41, 1'b0};
      vt[3] = '{4'b1111, 8'h2B, 9,  8'h6C, 1'b0, 3, 8'h6C, 1'b0};
      vt[4] = '{4'b1111, 8'h1A, 5,  8'h5D, 1'b0, 0, 8'h5D, 1'b0};
      vt[5] = '{4'b0001, 8'h1A, 12, 8'h5D, 1'b0, 0, 8'h5D, 1'b0};
      vt[6] = '{4'b0010, 8'h33, 4,  8'hFF, 1'b1, 1, 8'hFF, 1'b1};
      vt[7] = '{4'b0010, 8'h1B, 3,  8'h3F, 1'b0, 1, 8'h3F, 1'b0};
      vt[8] = '{4'b0100, 8'h2A, 16, 8'hAA, 1'b0, 2, 8'h00, 1'b1};
      vt[9] = '{4'b0100, 8'h2A, 15, 8'h41, 1'b0, 2, 8'h41, 1'b0};

      repeat (3) tick();
      chk("reset outputs", all_outs(), 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 10; i++)
         run_txn($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].lat, vt[i].d, vt[i].nk, vt[i].w, vt[i].ed, vt[i].ee);

      for (int i = 0; i < 10; i++) begin
         w = winner(4'b0101, ptr);
         chk($sformatf("fair%0d order", i), w, (i % 2 == 0) ? 0 : 2);
         d = 8'($urandom);
         run_txn($sformatf("fair%0d", i), 4'b0101, addr[w], $urandom_range(1, 10), d, 1'b0, w, d, 1'b0);
      end

      bus.req = '0;
      tick();
      bus.m_done = 1'b1;
      bus.m_data = 8'hEE;
      bus.m_nack = 1'b1;
      tick();
      bus.m_done = 1'b0;
      bus.m_nack = 1'b0;
      tick();
      chk("stray m_done ignored", {bus.resp_valid, bus.m_abort, bus.gnt}, 0);

      for (int i = 0; i < 40; i++) begin
         r   = 4'($urandom_range(1, 15));
         w   = winner(r, ptr);
         a   = 8'($urandom);
         d   = 8'($urandom);
         nk  = ($urandom_range(0, 3) == 0);
         lat = $urandom_range(1, 20);
         run_txn($sformatf("rnd%0d", i), r, a, lat, d, nk, w, (lat >= TIMEOUT) ? 8'h00 : d, (lat >= TIMEOUT) ? 1'b1 : nk);
      end

      addr[1] = 8'h1B;
      bus.req_addr = {addr[3], addr[2], addr[1], addr[0]};
      bus.req = 4'b0010;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.gnt == '0 && n < 8);
      chk("rst-seq gnt", bus.gnt, 4'b0010);
      bus.req = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid-wait reset outputs", all_outs(), 0);
      ptr = 0;
      bad = 1'b0;
      repeat (20) begin
         tick();
         if (bus.resp_valid != '0 || bus.m_abort) bad = 1'b1;
      end
      chk("no response after reset", bad, 0);
      run_txn("post-reset ptr", 4'b1010, 8'h1B, 4, 8'h3F, 1'b0, winner(4'b1010, ptr), 8'h3F, 1'b0);
      run_txn("post-reset req3", 4'b1000, 8'h2B, 4, 8'h6C, 1'b0, 3, 8'h6C, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
